// File: rtl/test_status_pkg.sv
// Shared types and default constants for the test status monitor.
package test_status_pkg;

  typedef enum logic [1:0] {
    RUN,
    PASS,
    FAIL,
    TIMEOUT
  } tsm_state_e;

  localparam logic [31:0] TSM_TOHOST_ADDR  = 32'h0000_1000;
  localparam logic [31:0] TSM_CONSOLE_ADDR = 32'h0000_1004;
  localparam logic [31:0] TSM_PASS_WORD    = 32'h0000_0001;

endpackage

// File: rtl/status_fifo.sv
// Synchronous FIFO with registered storage; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module status_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/test_status_monitor.sv
// Passive PASS/FAIL/TIMEOUT monitor on the data-memory write port.
// Define TSM_CONSOLE_EN to enable the byte console FIFO.
module test_status_monitor
  import test_status_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR  = TSM_TOHOST_ADDR,
  parameter logic [31:0] CONSOLE_ADDR = TSM_CONSOLE_ADDR,
  parameter int unsigned MAX_CYCLES   = 200,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dmem_req,
  input  logic             dmem_we,
  input  logic [31:0]      dmem_addr,
  input  logic [31:0]      dmem_wdata,
  input  logic [3:0]       dmem_be,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [30:0]      fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] store_count,
  output logic             con_valid,
  output logic [7:0]       con_data,
  input  logic             con_ready,
  output logic             con_overflow
);

  tsm_state_e       state_q, state_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic [30:0]      fail_code_q, fail_code_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] store_count_q, store_count_d;
  logic             wr_ev;
  logic             tohost_wr;

  assign wr_ev     = dmem_req && dmem_we;
  assign tohost_wr = wr_ev && (dmem_addr == TOHOST_ADDR) &&
                     (dmem_be == 4'hF) && dmem_wdata[0];

  // A tohost report on the last watchdog cycle takes priority over TIMEOUT.
  always_comb begin
    state_d       = state_q;
    fail_code_d   = fail_code_q;
    cycle_count_d = cycle_count_q;
    store_count_d = store_count_q;
    if (state_q == RUN) begin
      if (cycle_count_q != '1) begin
        cycle_count_d = cycle_count_q + CNT_W'(1);
      end
      if (wr_ev && (store_count_q != '1)) begin
        store_count_d = store_count_q + CNT_W'(1);
      end
      if (tohost_wr) begin
        if (dmem_wdata == TSM_PASS_WORD) begin
          state_d = PASS;
        end else begin
          state_d     = FAIL;
          fail_code_d = dmem_wdata[31:1];
        end
      end else if (cycle_count_q == CNT_W'(MAX_CYCLES - 1)) begin
        state_d = TIMEOUT;
      end
    end
    done_d    = (state_d != RUN);
    pass_d    = (state_d == PASS);
    timeout_d = (state_d == TIMEOUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      fail_code_q   <= '0;
      cycle_count_q <= '0;
      store_count_q <= '0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      fail_code_q   <= fail_code_d;
      cycle_count_q <= cycle_count_d;
      store_count_q <= store_count_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign fail_code   = fail_code_q;
  assign cycle_count = cycle_count_q;
  assign store_count = store_count_q;

`ifdef TSM_CONSOLE_EN
  logic con_push, con_pop, fifo_full, fifo_empty;
  logic con_overflow_q, con_overflow_d;

  assign con_push  = wr_ev && (dmem_addr == CONSOLE_ADDR) && dmem_be[0];
  assign con_valid = !fifo_empty;
  assign con_pop   = con_valid && con_ready;

  status_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_con_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (con_push),
    .pop   (con_pop),
    .wdata (dmem_wdata[7:0]),
    .rdata (con_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    con_overflow_d = con_overflow_q || (con_push && fifo_full && !con_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      con_overflow_q <= 1'b0;
    end else begin
      con_overflow_q <= con_overflow_d;
    end
  end

  assign con_overflow = con_overflow_q;
`else
  logic unused_con;

  assign unused_con   = con_ready ^ (dmem_addr == CONSOLE_ADDR) ^ (FIFO_DEPTH == 0);
  assign con_valid    = 1'b0;
  assign con_data     = '0;
  assign con_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_test_status_monitor.sv
// Self-checking bench for test_status_monitor; directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_test_status_monitor;

  localparam int unsigned MAXC  = 200;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] TH_A  = 32'h0000_1000;
  localparam logic [31:0] CON_A = 32'h0000_1004;
`ifdef TSM_CONSOLE_EN
  localparam bit CON_EN = 1'b1;
`else
  localparam bit CON_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        done, pass, timeout;
  logic [30:0] fail_code;
  logic [31:0] cycle_count, store_count;
  logic        con_valid, con_ready, con_overflow;
  logic [7:0]  con_data;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  bit          m_done, m_pass, m_timeout, m_ovf;
  logic [30:0] m_code;
  longint      m_cycles, m_stores;
  byte unsigned m_q[$];

  always #5 clk = ~clk;

  test_status_monitor #(
    .TOHOST_ADDR  (TH_A),
    .CONSOLE_ADDR (CON_A),
    .MAX_CYCLES   (MAXC),
    .CNT_W        (32),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .fail_code    (fail_code),
    .cycle_count  (cycle_count),
    .store_count  (store_count),
    .con_valid    (con_valid),
    .con_data     (con_data),
    .con_ready    (con_ready),
    .con_overflow (con_overflow)
  );

  function automatic void model_reset();
    m_done = 0; m_pass = 0; m_timeout = 0; m_ovf = 0;
    m_code = '0; m_cycles = 0; m_stores = 0;
    m_q.delete();
  endfunction

  function automatic void model_edge(bit wr, logic [31:0] addr, logic [31:0] wdata,
                                     logic [3:0] be, bit rdy);
    bit popped;
    if (CON_EN) begin
      popped = rdy && (m_q.size() > 0);
      if (popped) void'(m_q.pop_front());
      if (wr && addr == CON_A && be[0]) begin
        if (m_q.size() < DEPTH) m_q.push_back(wdata[7:0]);
        else m_ovf = 1;
      end
    end
    if (!m_done) begin
      if (wr && addr == TH_A && be == 4'hF && wdata[0]) begin
        m_done = 1;
        if (wdata == 32'd1) m_pass = 1;
        else m_code = wdata[31:1];
      end else if (m_cycles == MAXC - 1) begin
        m_done = 1;
        m_timeout = 1;
      end
      if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
      if (wr && m_stores < 64'hFFFF_FFFF) m_stores++;
    end
  endfunction

  task automatic step(input logic req, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input logic rdy);
    dmem_req = req; dmem_we = we; dmem_addr = addr;
    dmem_wdata = wdata; dmem_be = be; con_ready = rdy;
    @(posedge clk);
    model_edge(req && we, addr, wdata, be, rdy);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dmem_req = 0; dmem_we = 0; dmem_addr = '0; dmem_wdata = '0; dmem_be = '0; con_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dmem_req = 0; dmem_we = 0; dmem_addr = '0; dmem_wdata = '0; dmem_be = '0; con_ready = 0;
    #3;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b want 0", done); end
    vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL reset_pass: got %0b want 0", pass); end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %0b want 0", timeout); end
    vectors++; if (fail_code !== 31'd0) begin miscompares++; $display("FAIL reset_code: got %0d want 0", fail_code); end
    vectors++; if (cycle_count !== 32'd0) begin miscompares++; $display("FAIL reset_cycles: got %0d want 0", cycle_count); end
    vectors++; if (store_count !== 32'd0) begin miscompares++; $display("FAIL reset_stores: got %0d want 0", store_count); end
    vectors++; if (con_valid !== 1'b0 || con_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_console: got v=%0b o=%0b want 0 0", con_valid, con_overflow); end
    do_reset();
  endtask

  task automatic test_pass();
    do_reset();
    idle(10);
    vectors++; if (cycle_count !== 32'd10) begin miscompares++; $display("FAIL pass_precount: got %0d want 10", cycle_count); end
    step(1, 1, TH_A, 32'h1, 4'hF, 0);
    vectors++; if (done !== 1'b1 || pass !== 1'b1) begin miscompares++; $display("FAIL pass_flags: got done=%0b pass=%0b want 1 1", done, pass); end
    vectors++; if (timeout !== 1'b0 || fail_code !== 31'd0) begin miscompares++; $display("FAIL pass_excl: got to=%0b code=%0d want 0 0", timeout, fail_code); end
    vectors++; if (cycle_count !== 32'd11) begin miscompares++; $display("FAIL pass_cycles: got %0d want 11", cycle_count); end
    step(1, 1, TH_A, 32'h2B, 4'hF, 0);
    step(1, 1, 32'h2000, 32'h5, 4'hF, 0);
    idle(5);
    vectors++; if (pass !== 1'b1 || fail_code !== 31'd0) begin miscompares++; $display("FAIL pass_sticky: got pass=%0b code=%0d want 1 0", pass, fail_code); end
    vectors++; if (cycle_count !== 32'd11) begin miscompares++; $display("FAIL pass_freeze: got %0d want 11", cycle_count); end
    vectors++; if (store_count !== 32'd1) begin miscompares++; $display("FAIL pass_stores: got %0d want 1", store_count); end
  endtask

  task automatic test_fail();
    do_reset();
    idle(3);
    step(1, 1, TH_A, 32'h0000_002B, 4'hF, 0);
    vectors++; if (done !== 1'b1 || pass !== 1'b0) begin miscompares++; $display("FAIL fail_flags: got done=%0b pass=%0b want 1 0", done, pass); end
    vectors++; if (fail_code !== 31'd21) begin miscompares++; $display("FAIL fail_code: got %0d want 21", fail_code); end
    step(1, 1, TH_A, 32'h1, 4'hF, 0);
    idle(2);
    vectors++; if (pass !== 1'b0 || fail_code !== 31'd21 || timeout !== 1'b0) begin miscompares++; $display("FAIL fail_sticky: got pass=%0b code=%0d to=%0b want 0 21 0", pass, fail_code, timeout); end
  endtask

  task automatic test_timeout();
    do_reset();
    idle(MAXC - 1);
    vectors++; if (done !== 1'b0 || cycle_count !== 32'd199) begin miscompares++; $display("FAIL to_early: got done=%0b cyc=%0d want 0 199", done, cycle_count); end
    idle(1);
    vectors++; if (done !== 1'b1 || timeout !== 1'b1 || pass !== 1'b0) begin miscompares++; $display("FAIL to_flags: got done=%0b to=%0b pass=%0b want 1 1 0", done, timeout, pass); end
    vectors++; if (cycle_count !== 32'd200) begin miscompares++; $display("FAIL to_cycles: got %0d want 200", cycle_count); end
    step(1, 1, TH_A, 32'h1, 4'hF, 0);
    idle(3);
    vectors++; if (cycle_count !== 32'd200 || pass !== 1'b0) begin miscompares++; $display("FAIL to_freeze: got cyc=%0d pass=%0b want 200 0", cycle_count, pass); end
  endtask

  task automatic test_watchdog_race();
    do_reset();
    idle(MAXC - 1);
    step(1, 1, TH_A, 32'h1, 4'hF, 0);
    vectors++; if (pass !== 1'b1 || timeout !== 1'b0 || done !== 1'b1) begin miscompares++; $display("FAIL race: got pass=%0b to=%0b done=%0b want 1 0 1", pass, timeout, done); end
  endtask

  task automatic test_partial();
    do_reset();
    step(1, 1, TH_A, 32'h1, 4'h3, 0);
    step(1, 1, TH_A, 32'h2, 4'hF, 0);
    step(1, 0, TH_A, 32'h1, 4'hF, 0);
    idle(1);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL partial_done: got %0b want 0", done); end
    vectors++; if (store_count !== 32'd2) begin miscompares++; $display("FAIL partial_stores: got %0d want 2", store_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    idle(4);
    step(1, 1, TH_A, 32'h1, 4'hF, 0);
    vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL ar_pre: got pass=%0b want 1", pass); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (done !== 1'b0 || pass !== 1'b0 || timeout !== 1'b0) begin miscompares++; $display("FAIL ar_flags: got %0b%0b%0b want 000", done, pass, timeout); end
    vectors++; if (cycle_count !== 32'd0 || store_count !== 32'd0 || fail_code !== 31'd0) begin miscompares++; $display("FAIL ar_counts: got cyc=%0d st=%0d code=%0d want 0 0 0", cycle_count, store_count, fail_code); end
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    idle(1);
    vectors++; if (cycle_count !== 32'd1 || done !== 1'b0) begin miscompares++; $display("FAIL ar_resume: got cyc=%0d done=%0b want 1 0", cycle_count, done); end
  endtask

  task automatic test_console();
    byte unsigned ch;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      ch = 8'h41 + 8'(i);
      step(1, 1, CON_A, {24'h0, ch}, 4'h1, 0);
    end
    vectors++; if (store_count !== 32'd9) begin miscompares++; $display("FAIL con_stores: got %0d want 9", store_count); end
    if (CON_EN) begin
      vectors++; if (con_overflow !== 1'b1) begin miscompares++; $display("FAIL con_ovf: got %0b want 1", con_overflow); end
      for (int i = 0; i < 8; i++) begin
        ch = 8'h41 + 8'(i);
        vectors++; if (con_valid !== 1'b1 || con_data !== ch) begin miscompares++; $display("FAIL con_drain%0d: got v=%0b d=%02h want 1 %02h", i, con_valid, con_data, ch); end
        step(0, 0, '0, '0, '0, 1);
      end
      vectors++; if (con_valid !== 1'b0 || con_overflow !== 1'b1) begin miscompares++; $display("FAIL con_empty: got v=%0b o=%0b want 0 1", con_valid, con_overflow); end
    end else begin
      step(0, 0, '0, '0, '0, 1);
      vectors++; if (con_valid !== 1'b0 || con_overflow !== 1'b0 || con_data !== 8'h00) begin miscompares++; $display("FAIL con_off: got v=%0b o=%0b d=%02h want 0 0 00", con_valid, con_overflow, con_data); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, w;
    logic [3:0]  b;
    logic        rq, we, rdy;
    int unsigned r;
    for (int ep = 0; ep < 12; ep++) begin
      do_reset();
      for (int n = 0; n < int'($urandom_range(40, 260)); n++) begin
        rq = 1'($urandom_range(0, 1));
        we = ($urandom_range(0, 3) != 0);
        r  = $urandom_range(0, 31);
        a  = (r == 0) ? TH_A : (r <= 12) ? CON_A : 32'h2000 + 32'($urandom_range(0, 63)) * 4;
        b  = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
        w  = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom;
        rdy = 1'($urandom_range(0, 1));
        step(rq, we, a, w, b, rdy);
        vectors++; if (done !== m_done || pass !== m_pass || timeout !== m_timeout) begin miscompares++; $display("FAIL rnd_flags ep%0d n%0d: got %0b%0b%0b want %0b%0b%0b", ep, n, done, pass, timeout, m_done, m_pass, m_timeout); end
        vectors++; if (fail_code !== m_code) begin miscompares++; $display("FAIL rnd_code ep%0d n%0d: got %0d want %0d", ep, n, fail_code, m_code); end
        vectors++; if (cycle_count !== 32'(m_cycles) || store_count !== 32'(m_stores)) begin miscompares++; $display("FAIL rnd_counts ep%0d n%0d: got %0d/%0d want %0d/%0d", ep, n, cycle_count, store_count, m_cycles, m_stores); end
        vectors++; if (con_valid !== (m_q.size() != 0) || con_overflow !== m_ovf) begin miscompares++; $display("FAIL rnd_con ep%0d n%0d: got v=%0b o=%0b want v=%0b o=%0b", ep, n, con_valid, con_overflow, m_q.size() != 0, m_ovf); end
        if (m_q.size() != 0) begin
          vectors++; if (con_data !== m_q[0]) begin miscompares++; $display("FAIL rnd_data ep%0d n%0d: got %02h want %02h", ep, n, con_data, m_q[0]); end
        end else if (!CON_EN) begin
          vectors++; if (con_data !== 8'h00) begin miscompares++; $display("FAIL rnd_data0 ep%0d n%0d: got %02h want 00", ep, n, con_data); end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_watchdog_race();
    test_partial();
    test_async_reset();
    test_console();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/test_status_monitor.md
Name: test_status_monitor

Overview:
- Passive synthesizable monitor on the core's data-memory write port, placed alongside `top` inside the simulation harness.
- Snoops stores to a "tohost" word and decides PASS or FAIL with a code.
- Runs a cycle watchdog that ends the run with TIMEOUT.
- Gives the harness a single done/result interface, replacing fixed cycle-count termination.

Parameters:
- TOHOST_ADDR, 32'h0000_1000, word address whose stores report the test result
- CONSOLE_ADDR, 32'h0000_1004, byte-console address (used only with the optional feature)
- MAX_CYCLES, 200, watchdog limit in clock cycles after reset release
- CNT_W, 32, width of the cycle and store counters
- FIFO_DEPTH, 8, console FIFO entries (power of two, at least 2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- dmem_req  in  1  data-memory request valid
- dmem_we  in  1  request is a write
- dmem_addr  in  32  byte address
- dmem_wdata  in  32  write data
- dmem_be  in  4  byte enables
- done  out  1  run finished (sticky)
- pass  out  1  finished with PASS
- timeout  out  1  finished with TIMEOUT
- fail_code  out  31  code reported on FAIL, else 0
- cycle_count  out  CNT_W  cycles elapsed in RUN
- store_count  out  CNT_W  write requests observed in RUN
- con_valid  out  1  console byte available
- con_data  out  8  console byte
- con_ready  in  1  harness accepts console byte
- con_overflow  out  1  sticky: a console byte was dropped

Behaviour:
- Clock and reset: one clock `clk`. `reset` is asynchronous, active-high. The block never stalls the bus and has no ready output.
- Reset values: state=RUN; done, pass, timeout, con_valid and con_overflow all 0; fail_code, cycle_count, store_count and the FIFO all zero/empty. Asserting reset in any state, including a terminal one, returns the block to these values immediately.
- Write event: dmem_req & dmem_we in the same cycle.
- State RUN:
  - cycle_count increments every cycle and saturates at its maximum value.
  - store_count increments on every write event and saturates.
- Tohost write: write event with dmem_addr == TOHOST_ADDR and dmem_be == 4'hF.
  - wdata == 1 → PASS.
  - wdata[0] == 1 and wdata != 1 → FAIL, with fail_code = wdata[31:1].
  - wdata[0] == 0 → ignored and the block stays in RUN.
  - Partial-strobe writes to TOHOST_ADDR are ignored.
- Watchdog: when cycle_count == MAX_CYCLES-1 and there is no qualifying tohost write that cycle, the next state is TIMEOUT. A qualifying tohost write in that same cycle wins.
- Latency: outputs update on the clock edge that samples the write event, so done is visible the following cycle.
  - PASS: done=1, pass=1.
  - FAIL: done=1, pass=0, fail_code set.
  - TIMEOUT: done=1, timeout=1.
- Terminal states PASS, FAIL and TIMEOUT are sticky until reset. Counters freeze, and later writes (including tohost writes) are ignored.
- pass, timeout and a nonzero fail_code are mutually exclusive.

Optional Feature:
- Macro: TSM_CONSOLE_EN.
- With the macro:
  - A write event to CONSOLE_ADDR with dmem_be[0] == 1 pushes dmem_wdata[7:0] into a FIFO_DEPTH-entry FIFO.
  - Output is first-word-fall-through: con_valid = FIFO non-empty, and con_data is the head entry.
  - A pop occurs when con_valid & con_ready.
  - Push while full with no simultaneous pop: the byte is dropped and con_overflow sets (sticky).
  - Push and pop in the same cycle while full: the push succeeds and occupancy is unchanged.
  - Console pushes continue after done until reset.
- Without the macro:
  - Ports remain. con_valid=0, con_data=0, con_overflow=0, con_ready is ignored, and console writes are ignored.
  - Console writes still count in store_count.

Decomposition:
- Package test_status_pkg holds:
  - state enum {RUN, PASS, FAIL, TIMEOUT}
  - default address constants
  - the PASS word constant (32'h1)
- Sub-module status_fifo: parameterized synchronous FIFO with push, pop, full, empty and async active-high reset. It is instantiated only under TSM_CONSOLE_EN.

Test Plan:
- Write 32'h1 to 32'h1000 with be=4'hF at cycle 10 → done=1 and pass=1 from cycle 11. Later writes do not change outputs, and cycle_count freezes at 11.
- Write 32'h0000_002B to TOHOST_ADDR → done=1, pass=0, fail_code=21. A subsequent write of 32'h1 is ignored.
- No tohost writes with MAX_CYCLES=200 → timeout=1 and done=1 after 200 cycles, with cycle_count=200. A tohost write of 32'h1 exactly at cycle_count=199 → pass=1 and timeout=0.
- Write 32'h1 with be=4'h3, then 32'h2 with be=4'hF → both ignored, state stays RUN, store_count=2.
- Assert reset in the PASS state → all outputs return to zero asynchronously. After release, normal RUN resumes from cycle_count=0.
- With TSM_CONSOLE_EN and con_ready=0, write 9 bytes 'A'..'I' → 8 are held and con_overflow=1. With con_ready=1 they drain as 'A'..'H' in order, then con_valid=0.
